// File: rtl/pma.sv
// pma: transmit-side PMA serializer.
// Loads a parallel word and shifts it out LSB-first, one bit per clock, on a differential pair.
`default_nettype none

module pma #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  Bit_Rate_Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  MAC_Data_En,
  output logic                  TX_Out_P,
  output logic                  TX_Out_N
);

  localparam int              CW   = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] TRANSMIT = 2'b01;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        if (MAC_Data_En) begin
          word_d  = Data_in;
          cnt_d   = '0;
          state_d = TRANSMIT;
        end
      end
      TRANSMIT: begin
        // Any count at or past the last bit ends the word, so a corrupted
        // counter can never run beyond the word.
        if (cnt_q < LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else if (MAC_Data_En) begin
          word_d = Data_in;
          cnt_d  = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Bit_Rate_Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign TX_Out_P = (state_q == TRANSMIT) ? word_q[cnt_q] : 1'b0;
  assign TX_Out_N = ~TX_Out_P;

endmodule

`default_nettype wire

// File: tb/tb_pma.sv
// tb_pma: directed and random stimulus on 10-bit and 8-bit serializers against a bit-queue model.
`default_nettype none

module tb_pma;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] data10;
  logic [7:0] data8;
  logic       p10, n10, p8, n8;

  int tests  = 0;
  int failed = 0;

  // Expected serial bits still to be sent; front is the bit on the wire now.
  bit q10[$];
  bit q8[$];

  always #5 clk = ~clk;

  pma #(.DATA_WIDTH(10)) dut10 (
    .Bit_Rate_Clk(clk), .Rst_n(rst_n), .Data_in(data10),
    .MAC_Data_En(en), .TX_Out_P(p10), .TX_Out_N(n10)
  );

  pma #(.DATA_WIDTH(8)) dut8 (
    .Bit_Rate_Clk(clk), .Rst_n(rst_n), .Data_in(data8),
    .MAC_Data_En(en), .TX_Out_P(p8), .TX_Out_N(n8)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply inputs for one edge, advance the model, then check both DUTs.
  task automatic step(input logic r, input logic e, input logic [9:0] d10,
                      input logic [7:0] d8, input string tag);
    bit exp10, exp8;
    rst_n  = r;
    en     = e;
    data10 = d10;
    data8  = d8;
    @(posedge clk);
    if (!r) begin
      q10.delete();
      q8.delete();
    end else begin
      if (q10.size() != 0) void'(q10.pop_front());
      if (q8.size()  != 0) void'(q8.pop_front());
      if (q10.size() == 0 && e) for (int i = 0; i < 10; i++) q10.push_back(d10[i]);
      if (q8.size()  == 0 && e) for (int i = 0; i < 8;  i++) q8.push_back(d8[i]);
    end
    exp10 = (q10.size() != 0) ? q10[0] : 1'b0;
    exp8  = (q8.size()  != 0) ? q8[0]  : 1'b0;
    #1;
    check({tag, "_p10"}, p10, exp10);
    check({tag, "_n10"}, n10, ~exp10);
    check({tag, "_p8"},  p8,  exp8);
    check({tag, "_n8"},  n8,  ~exp8);
  endtask

  initial begin
    logic [9:0] rd10;
    logic [7:0] rd8;
    logic       re, rr;

    rst_n = 1'b0; en = 1'b0; data10 = '0; data8 = '0;
    #2;

    // Reset held with enable asserted: nothing may start.
    step(1'b0, 1'b1, 10'h3FF, 8'hFF, "reset");
    step(1'b0, 1'b1, 10'h3FF, 8'hFF, "reset");
    step(1'b1, 1'b0, 10'h3FF, 8'hFF, "post_reset");

    // Single word: 100 on the 10-bit lane, A5 on the 8-bit lane.
    step(1'b1, 1'b1, 10'd100, 8'hA5, "single_load");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 10'h000, 8'h00, "single");

    // Back-to-back words with enable held high.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10'd100, 8'h3C, "b2b_w0");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10'd200, 8'hC3, "b2b_w1");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 10'd30,  8'h5A, "b2b_w2");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 10'd0,   8'h00, "b2b_tail");

    // Mid-word disturbance: data and enable change at cnt=4.
    step(1'b1, 1'b1, 10'h2AA, 8'hAA, "dist_load");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 10'h2AA, 8'hAA, "dist_a");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'h155, 8'h55, "dist_b");

    // Reset mid-word, then a fresh word from bit 0.
    step(1'b1, 1'b1, 10'h3FF, 8'hFF, "rmw_load");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h000, 8'h00, "rmw_run");
    step(1'b0, 1'b0, 10'h000, 8'h00, "rmw_reset");
    step(1'b1, 1'b0, 10'h000, 8'h00, "rmw_idle");
    step(1'b1, 1'b1, 10'h0F1, 8'h0E, "rmw_new");
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 10'h000, 8'h00, "rmw_new_run");

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rd10 = 10'($urandom);
      rd8  = 8'($urandom);
      re   = ($urandom_range(0, 9) < 7);
      rr   = ($urandom_range(0, 49) != 0);
      step(rr, re, rd10, rd8, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
